// File: rtl/vga_draw_pkg.sv
// Shared drawing-engine definitions: FSM encoding and
// resolution-derived coordinate widths and screen bounds.
package vga_draw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  // Resolution strings are all seven characters wide.
  function automatic int res_nx(input logic [55:0] r);
    if (r == "320x240") return 9;
    if (r == "160x120") return 8;
    return 10;
  endfunction

  function automatic int res_ny(input logic [55:0] r);
    if (r == "320x240") return 8;
    if (r == "160x120") return 7;
    return 9;
  endfunction

  function automatic int res_cols(input logic [55:0] r);
    if (r == "320x240") return 320;
    if (r == "160x120") return 160;
    return 640;
  endfunction

  function automatic int res_rows(input logic [55:0] r);
    if (r == "320x240") return 240;
    if (r == "160x120") return 120;
    return 480;
  endfunction

endpackage

// File: rtl/vga_raster_counter.sv
// 2D raster counter: i runs 0..w-1 inside j 0..h-1, exposes
// the next step combinationally and flags the final pixel.
module vga_raster_counter #(
  parameter int nX = 10,
  parameter int nY = 9
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          i_load,
  input  logic          i_step,
  input  logic [nX-1:0] i_w,
  input  logic [nY-1:0] i_h,
  output logic [nX-1:0] o_i_nxt,
  output logic [nY-1:0] o_j_nxt,
  output logic          o_last
);

  logic [nX-1:0] r_i;
  logic [nY-1:0] r_j;
  logic          w_eol;

  assign w_eol   = (r_i == i_w - 1'b1);
  assign o_last  = w_eol && (r_j == i_h - 1'b1);
  assign o_i_nxt = w_eol ? '0 : r_i + 1'b1;
  assign o_j_nxt = w_eol ? r_j + 1'b1 : r_j;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_i <= '0;
      r_j <= '0;
    end else if (i_load) begin
      r_i <= '0;
      r_j <= '0;
    end else if (i_step) begin
      r_i <= o_i_nxt;
      r_j <= o_j_nxt;
    end
  end

endmodule

// File: rtl/vga_rect_filler.sv
// Rectangle fill engine feeding the VGA adapter pixel port.
// Define VGA_RECT_CLIP_EN to mask writes outside the screen.
module vga_rect_filler
  import vga_draw_pkg::*;
#(
  parameter logic [55:0] RESOLUTION  = "640x480",
  parameter int          COLOR_DEPTH = 9,
  localparam int         nX = res_nx(RESOLUTION),
  localparam int         nY = res_ny(RESOLUTION)
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [nX-1:0]          cmd_x,
  input  logic [nY-1:0]          cmd_y,
  input  logic [nX-1:0]          cmd_w,
  input  logic [nY-1:0]          cmd_h,
  input  logic [COLOR_DEPTH-1:0] cmd_color,
  output logic [nX-1:0]          x,
  output logic [nY-1:0]          y,
  output logic [COLOR_DEPTH-1:0] color,
  output logic                   write,
  output logic                   busy,
  output logic                   done
);

  state_t r_state, w_next;

  logic [nX-1:0]          r_x0, r_w, r_x;
  logic [nY-1:0]          r_y0, r_h, r_y;
  logic [COLOR_DEPTH-1:0] r_col, r_color;
  logic                   r_write;

  logic          w_hs, w_empty, w_last, w_pix, w_wr;
  logic [nX-1:0] w_i_nxt, w_bx, w_oi, w_xo;
  logic [nY-1:0] w_j_nxt, w_by, w_oj, w_yo;

  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state == FILL);
  assign done      = (r_state == DONE);
  assign x         = r_x;
  assign y         = r_y;
  assign color     = r_color;
  assign write     = r_write;

  assign w_hs    = cmd_valid && cmd_ready;
  assign w_empty = (cmd_w == '0) || (cmd_h == '0);

  vga_raster_counter #(.nX(nX), .nY(nY)) u_cnt (
    .clock   (clock),
    .resetn  (resetn),
    .i_load  (w_hs),
    .i_step  (busy),
    .i_w     (r_w),
    .i_h     (r_h),
    .o_i_nxt (w_i_nxt),
    .o_j_nxt (w_j_nxt),
    .o_last  (w_last)
  );

  // The pixel registered at an edge is the one shown next cycle,
  // so the handshake edge emits (x0,y0) straight from the command.
  assign w_bx  = w_hs ? cmd_x : r_x0;
  assign w_by  = w_hs ? cmd_y : r_y0;
  assign w_oi  = w_hs ? '0 : w_i_nxt;
  assign w_oj  = w_hs ? '0 : w_j_nxt;
  assign w_pix = (w_hs && !w_empty) || (busy && !w_last);

`ifdef VGA_RECT_CLIP_EN
  localparam int COLS = res_cols(RESOLUTION);
  localparam int ROWS = res_rows(RESOLUTION);
  localparam logic [nX:0] COLS_L = COLS[nX:0];
  localparam logic [nY:0] ROWS_L = ROWS[nY:0];

  logic [nX:0] w_xs;
  logic [nY:0] w_ys;

  assign w_xs = {1'b0, w_bx} + {1'b0, w_oi};
  assign w_ys = {1'b0, w_by} + {1'b0, w_oj};
  assign w_xo = w_xs[nX-1:0];
  assign w_yo = w_ys[nY-1:0];
  assign w_wr = w_pix && (w_xs < COLS_L) && (w_ys < ROWS_L);
`else
  assign w_xo = w_bx + w_oi;
  assign w_yo = w_by + w_oj;
  assign w_wr = w_pix;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_hs) w_next = w_empty ? DONE : FILL;
      FILL:    if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_x0    <= '0;
      r_y0    <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_col   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_color <= '0;
      r_write <= 1'b0;
    end else begin
      r_write <= w_wr;
      if (w_hs) begin
        r_x0  <= cmd_x;
        r_y0  <= cmd_y;
        r_w   <= cmd_w;
        r_h   <= cmd_h;
        r_col <= cmd_color;
      end
      if (w_pix) begin
        r_x     <= w_xo;
        r_y     <= w_yo;
        r_color <= w_hs ? cmd_color : r_col;
      end
    end
  end

endmodule

// File: tb/tb_vga_rect_filler.sv
// Scoreboard bench for vga_rect_filler at 640x480, 9-bit color.
module tb_vga_rect_filler;

  logic       clock = 0;
  logic       resetn = 0;
  logic       cmd_valid = 0;
  logic       cmd_ready;
  logic [9:0] cmd_x = 0;
  logic [8:0] cmd_y = 0;
  logic [9:0] cmd_w = 0;
  logic [8:0] cmd_h = 0;
  logic [8:0] cmd_color = 0;
  logic [9:0] x;
  logic [8:0] y;
  logic [8:0] color;
  logic       write, busy, done;

  vga_rect_filler dut (
    .clock(clock), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w),
    .cmd_h(cmd_h), .cmd_color(cmd_color),
    .x(x), .y(y), .color(color),
    .write(write), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit is_done;
    int ex;
    int ey;
    int ec;
  } ev_t;

  ev_t q[$];
  int  n_tests = 0;
  int  n_fail = 0;
  int  n_writes = 0;
  int  n_done = 0;
  int  cyc = 0;
  int  hs_q[$];

  always @(posedge clock) begin
    if (resetn && cmd_valid && cmd_ready) hs_q.push_back(cyc);
    cyc++;
  end

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: every write/done the DUT shows must match the queue head.
  initial forever begin
    @(negedge clock);
    if (resetn && write) begin
      ev_t e;
      n_writes++;
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL pix: unexpected write (%0d,%0d)", x, y);
      end else begin
        e = q.pop_front();
        if (e.is_done || x != e.ex || y != e.ey || color != e.ec) begin
          n_fail++;
          $display("FAIL pix: got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d) done=%0d",
                   x, y, color, e.ex, e.ey, e.ec, e.is_done);
        end
      end
    end
    if (resetn && done) begin
      ev_t e;
      n_done++;
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL done: unexpected done pulse");
      end else begin
        e = q.pop_front();
        if (!e.is_done) begin
          n_fail++;
          $display("FAIL done: got done expected pixel (%0d,%0d)", e.ex, e.ey);
        end
      end
    end
  end

  task automatic push_pix(input int px, input int py, input int c);
    ev_t e;
    e.is_done = 0;
`ifdef VGA_RECT_CLIP_EN
    if (px >= 640 || py >= 480) return;
`endif
    e.ex = px % 1024;
    e.ey = py % 512;
    e.ec = c;
    q.push_back(e);
  endtask

  task automatic push_done();
    ev_t e;
    e.is_done = 1;
    e.ex = 0;
    e.ey = 0;
    e.ec = 0;
    q.push_back(e);
  endtask

  task automatic push_rect(input int px, input int py, input int w,
                           input int h, input int c);
    for (int j = 0; j < h; j++)
      for (int i = 0; i < w; i++)
        push_pix(px + i, py + j, c);
    push_done();
  endtask

  task automatic issue(input int px, input int py, input int w,
                       input int h, input int c);
    int k = 0;
    @(negedge clock);
    while (!cmd_ready && k < 100) begin
      @(negedge clock);
      k++;
    end
    cmd_valid = 1;
    cmd_x = px[9:0];
    cmd_y = py[8:0];
    cmd_w = w[9:0];
    cmd_h = h[8:0];
    cmd_color = c[8:0];
    @(posedge clock);
    #1;
    cmd_valid = 0;
    cmd_x = 10'($urandom);
    cmd_y = 9'($urandom);
    cmd_w = 10'($urandom);
    cmd_h = 9'($urandom);
    cmd_color = 9'($urandom);
  endtask

  task automatic wait_done(input string name, input int exp_cyc,
                           input bit no_busy);
    int k;
    bit saw_busy = 0;
    for (k = 1; k <= exp_cyc + 20; k++) begin
      @(negedge clock);
      if (busy) saw_busy = 1;
      if (done) break;
    end
    check({name, " done latency"}, k, exp_cyc);
    if (no_busy) check({name, " busy seen"}, int'(saw_busy), 0);
    @(negedge clock);
    check({name, " ready after done"}, int'(cmd_ready), 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int w0, d0, h0;

    // Reset with a command pending: no transfer may happen.
    cmd_valid = 1;
    cmd_w = 3;
    cmd_h = 3;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset outputs", {write, busy, done, x, y, color}, 0);
    check("reset ready", int'(cmd_ready), 1);
    cmd_valid = 0;
    resetn = 1;
    repeat (2) @(negedge clock);
    check("no reset handshake", hs_q.size(), 0);

    // Basic 3x2 fill.
    w0 = n_writes;
    push_rect(10, 20, 3, 2, 'h1FF);
    issue(10, 20, 3, 2, 'h1FF);
    wait_done("rect3x2", 7, 0);
    check("rect3x2 writes", n_writes - w0, 6);

    // Empty commands.
    w0 = n_writes;
    push_done();
    issue(5, 5, 0, 5, 'h0F0);
    wait_done("w0", 1, 1);
    push_done();
    issue(5, 5, 7, 0, 'h00F);
    wait_done("h0", 1, 1);
    check("empty writes", n_writes - w0, 0);

    // Back-to-back with cmd_valid held.
    w0 = n_writes;
    d0 = n_done;
    h0 = hs_q.size();
    push_rect(1, 2, 1, 1, 'h003);
    push_rect(7, 8, 2, 1, 'h155);
    @(negedge clock);
    cmd_valid = 1;
    cmd_x = 1; cmd_y = 2; cmd_w = 1; cmd_h = 1; cmd_color = 'h003;
    @(posedge clock);
    #1;
    cmd_x = 7; cmd_y = 8; cmd_w = 2; cmd_h = 1; cmd_color = 'h155;
    for (int k = 0; k < 20 && hs_q.size() < h0 + 2; k++) begin
      @(posedge clock);
      #1;
    end
    cmd_valid = 0;
    check("b2b handshakes", hs_q.size() - h0, 2);
    if (hs_q.size() >= h0 + 2)
      check("b2b spacing", hs_q[h0+1] - hs_q[h0], 3);
    repeat (6) @(negedge clock);
    check("b2b writes", n_writes - w0, 3);
    check("b2b dones", n_done - d0, 2);

    // Reset in the middle of a 4x4 fill after five pixels.
    d0 = n_done;
    for (int i = 0; i < 5; i++) push_pix(100 + (i % 4), 50 + (i / 4), 'h0AA);
    issue(100, 50, 4, 4, 'h0AA);
    repeat (5) @(negedge clock);
    #2;
    resetn = 0;
    #1;
    check("abort outputs", {write, busy, done}, 0);
    @(negedge clock);
    resetn = 1;
    check("abort ready", int'(cmd_ready), 1);
    check("abort queue", q.size(), 0);
    check("abort no done", n_done - d0, 0);
    w0 = n_writes;
    push_rect(3, 4, 1, 1, 'h1C7);
    issue(3, 4, 1, 1, 'h1C7);
    wait_done("post-abort", 2, 0);
    check("post-abort writes", n_writes - w0, 1);

    // Right and bottom edge behaviour.
    w0 = n_writes;
    push_rect(638, 0, 4, 1, 'h011);
    issue(638, 0, 4, 1, 'h011);
    wait_done("right edge", 5, 0);
`ifdef VGA_RECT_CLIP_EN
    check("right edge writes", n_writes - w0, 2);
`else
    check("right edge writes", n_writes - w0, 4);
`endif
    w0 = n_writes;
    push_rect(639, 479, 1, 3, 'h1AB);
    issue(639, 479, 1, 3, 'h1AB);
    wait_done("bottom edge", 4, 0);
`ifdef VGA_RECT_CLIP_EN
    check("bottom edge writes", n_writes - w0, 1);
`else
    check("bottom edge writes", n_writes - w0, 3);
`endif

    repeat (3) @(negedge clock);
    check("queue drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
